// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared player-state codes, screen geometry and helpers.
// Revision    : 1.0
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_AIR    = 2'd2,
        ST_ATTACK = 2'd3
    } player_state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPRITE_W = 40;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync
// Description : Two-flop synchronizer for one asynchronous button input.
// Revision    : 1.0
// ============================================================================
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/player_controller.sv
`default_nettype none
// ============================================================================
// Module      : player_controller
// Description : Per-player movement/jump/attack logic, advanced once per frame.
// Revision    : 1.0
// ============================================================================
module player_controller #(
    parameter int START_X         = 20,
    parameter int GROUND_Y        = 400,
    parameter int MIN_X           = 0,
    parameter int MAX_X           = game_pkg::SCREEN_W - game_pkg::SPRITE_W,
    parameter int SPRITE_W        = game_pkg::SPRITE_W,
    parameter int WALK_SPEED      = 4,
    parameter int JUMP_VEL        = 12,
    parameter int GRAVITY         = 1,
    parameter int ATTACK_FRAMES   = 8,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int REACH           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic [9:0] opp_x,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [1:0] state,
    output logic       facing,
    output logic       hit
);
    import game_pkg::*;

    localparam logic signed [11:0] c_walk     = 12'(WALK_SPEED);
    localparam logic signed [11:0] c_min_x    = 12'(MIN_X);
    localparam logic signed [11:0] c_max_x    = 12'(MAX_X);
    localparam logic signed [11:0] c_sprite_w = 12'(SPRITE_W);
    localparam logic signed [11:0] c_ground   = 12'(GROUND_Y);
    localparam logic signed [7:0]  c_grav     = 8'(GRAVITY);
    localparam logic [7:0]         c_atk      = 8'(ATTACK_FRAMES);
    localparam logic [7:0]         c_cool     = 8'(COOLDOWN_FRAMES);

    logic [3:0] w_btn_raw;
    logic [3:0] w_btn;

    assign w_btn_raw = {btn_attack, btn_jump, btn_right, btn_left};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            btn_sync u_sync (
                .clk      (clk),
                .rst      (rst),
                .async_in (w_btn_raw[gi]),
                .sync_out (w_btn[gi])
            );
        end
    endgenerate

    player_state_e     r_state, w_state_nxt;
    logic [9:0]        r_pos_x, w_x_nxt;
    logic [9:0]        r_pos_y, w_y_nxt;
    logic signed [7:0] r_vel_y, w_vel_nxt;
    logic [7:0]        r_atk_cnt, w_atk_nxt;
    logic [7:0]        r_cooldown, w_cool_nxt;
    logic              r_facing, w_facing_nxt;
    logic              r_hit, w_hit_nxt;

    logic signed [11:0] w_dx, w_x_step, w_x_new, w_opp, w_y_sum;
    logic [9:0]         w_x_fin;
    logic               w_in_range;

    assign w_opp      = $signed({2'b00, opp_x});
    assign w_y_sum    = $signed({2'b00, r_pos_y}) + $signed({{4{r_vel_y[7]}}, r_vel_y});
    assign w_in_range = abs_diff(r_pos_x, opp_x) <= 10'(SPRITE_W + REACH);

    // Horizontal step: screen clamp first, then keep sprites from overlapping.
    always_comb begin
        w_dx = '0;
        if (w_btn[0] && !w_btn[1])
            w_dx = -c_walk;
        else if (w_btn[1] && !w_btn[0])
            w_dx = c_walk;

        w_x_step = $signed({2'b00, r_pos_x}) + w_dx;
        if (w_x_step < c_min_x)
            w_x_new = c_min_x;
        else if (w_x_step > c_max_x)
            w_x_new = c_max_x;
        else
            w_x_new = w_x_step;

        if (w_dx > 0 && r_pos_x < opp_x && w_x_new > (w_opp - c_sprite_w))
            w_x_new = w_opp - c_sprite_w;
        if (w_dx < 0 && r_pos_x > opp_x && w_x_new < (w_opp + c_sprite_w))
            w_x_new = w_opp + c_sprite_w;

        w_x_fin = w_x_new[11] ? '0 : w_x_new[9:0];
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_pos_x;
        w_y_nxt      = r_pos_y;
        w_vel_nxt    = r_vel_y;
        w_atk_nxt    = r_atk_cnt;
        w_cool_nxt   = r_cooldown;
        w_facing_nxt = r_facing;
        w_hit_nxt    = 1'b0;

        if (frame_tick) begin
            unique case (r_state)
                ST_IDLE, ST_MOVE: begin
                    w_cool_nxt = (r_cooldown != '0) ? r_cooldown - 8'd1 : '0;
                    if (w_btn[3] && r_cooldown == '0) begin
                        w_state_nxt = ST_ATTACK;
                        w_atk_nxt   = c_atk;
                        w_hit_nxt   = w_in_range;
                    end else begin
                        w_x_nxt = w_x_fin;
                        if (w_dx != '0)
                            w_facing_nxt = (w_dx > 0);
                        if (w_btn[2]) begin
                            w_state_nxt = ST_AIR;
                            w_y_nxt     = 10'(GROUND_Y - JUMP_VEL);
                            w_vel_nxt   = 8'(GRAVITY - JUMP_VEL);
                        end else begin
                            w_state_nxt = (w_dx != '0) ? ST_MOVE : ST_IDLE;
                        end
                    end
                end
                ST_AIR: begin
                    w_x_nxt = w_x_fin;
                    if (w_dx != '0)
                        w_facing_nxt = (w_dx > 0);
                    if (w_y_sum >= c_ground) begin
                        w_y_nxt     = 10'(GROUND_Y);
                        w_vel_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_y_nxt   = w_y_sum[9:0];
                        w_vel_nxt = r_vel_y + c_grav;
                    end
                end
                ST_ATTACK: begin
                    if (r_atk_cnt <= 8'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_atk_nxt   = '0;
                        w_cool_nxt  = c_cool;
                    end else begin
                        w_atk_nxt = r_atk_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_pos_x    <= 10'(START_X);
            r_pos_y    <= 10'(GROUND_Y);
            r_vel_y    <= '0;
            r_atk_cnt  <= '0;
            r_cooldown <= '0;
            r_facing   <= 1'b1;
            r_hit      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pos_x    <= w_x_nxt;
            r_pos_y    <= w_y_nxt;
            r_vel_y    <= w_vel_nxt;
            r_atk_cnt  <= w_atk_nxt;
            r_cooldown <= w_cool_nxt;
            r_facing   <= w_facing_nxt;
            r_hit      <= w_hit_nxt;
        end
    end

    assign pos_x  = r_pos_x;
    assign pos_y  = r_pos_y;
    assign state  = r_state;
    assign facing = r_facing;
    assign hit    = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_player_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_controller
// Description : Scoreboard bench for player_controller with directed frames.
// Revision    : 1.0
// ============================================================================
module tb_player_controller;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       btn_left, btn_right, btn_jump, btn_attack;
    logic [9:0] opp_x;
    logic [9:0] pos_x, pos_y;
    logic [1:0] state;
    logic       facing, hit;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] st;
        logic       f;
        logic       h;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   jump_y [25] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322,
                          322, 323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};

    player_controller u_dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_jump   (btn_jump),
        .btn_attack (btn_attack),
        .opp_x      (opp_x),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .state      (state),
        .facing     (facing),
        .hit        (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one frame tick (after the button synchronizers settle) and queues its expectation.
    task automatic tick(input logic [9:0] x, input logic [9:0] y, input logic [1:0] st,
                        input logic f, input logic h);
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        e.x = x; e.y = y; e.st = st; e.f = f; e.h = h;
        exp_q.push_back(e);
        frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
    endtask

    task automatic check_now(input string name, input logic [9:0] x, input logic [9:0] y,
                             input logic [1:0] st, input logic f, input logic h);
        n_cmp++;
        if ({pos_x, pos_y, state, facing, hit} !== {x, y, st, f, h}) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d st=%0d f=%0b h=%0b, want x=%0d y=%0d st=%0d f=%0b h=%0b",
                     name, pos_x, pos_y, state, facing, hit, x, y, st, f, h);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin : p_monitor
        logic t;
        exp_t e;
        int   idx;
        idx = 0;
        forever begin
            @(posedge clk);
            t = frame_tick & rst;
            @(negedge clk);
            if (t) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame: no expectation queued at frame %0d", idx);
                end else begin
                    e = exp_q.pop_front();
                    if ({pos_x, pos_y, state, facing, hit} !== e) begin
                        n_fail++;
                        $display("FAIL frame%0d: got x=%0d y=%0d st=%0d f=%0b h=%0b, want x=%0d y=%0d st=%0d f=%0b h=%0b",
                                 idx, pos_x, pos_y, state, facing, hit, e.x, e.y, e.st, e.f, e.h);
                    end
                end
                idx++;
            end else if (rst) begin
                n_cmp++;
                if (hit !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hit_outside_entry: got hit=%0b, want 0", hit);
                end
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : p_stim
        int ex;
        rst = 1'b0; frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; btn_attack = 1'b0;
        opp_x = 10'd300;
        repeat (3) @(posedge clk);
        #1 check_now("reset_state", 10'd20, 10'd400, 2'd0, 1'b1, 1'b0);
        rst = 1'b1;

        // Walk right, stop, one step left
        btn_right = 1'b1;
        for (int k = 1; k <= 4; k++) tick(10'(20 + 4 * k), 10'd400, 2'd1, 1'b1, 1'b0);
        btn_right = 1'b0;
        tick(10'd36, 10'd400, 2'd0, 1'b1, 1'b0);
        btn_left = 1'b1;
        tick(10'd32, 10'd400, 2'd1, 1'b0, 1'b0);
        btn_left = 1'b0;
        tick(10'd32, 10'd400, 2'd0, 1'b0, 1'b0);

        // Full jump arc
        btn_jump = 1'b1;
        tick(10'd32, 10'(jump_y[0]), 2'd2, 1'b0, 1'b0);
        btn_jump = 1'b0;
        for (int k = 1; k < 25; k++)
            tick(10'd32, 10'(jump_y[k]), (k == 24) ? 2'd0 : 2'd2, 1'b0, 1'b0);

        // Asynchronous reset mid-jump at y=350
        btn_jump = 1'b1;
        tick(10'd32, 10'd388, 2'd2, 1'b0, 1'b0);
        btn_jump = 1'b0;
        for (int k = 1; k <= 4; k++) tick(10'd32, 10'(jump_y[k]), 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check_now("reset_mid_jump", 10'd20, 10'd400, 2'd0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Opponent blocks rightward walk at opp_x-40, then leftward at opp_x+40
        opp_x = 10'd134;
        btn_right = 1'b1;
        for (int k = 1; k <= 18; k++) tick(10'(20 + 4 * k), 10'd400, 2'd1, 1'b1, 1'b0);
        tick(10'd94, 10'd400, 2'd1, 1'b1, 1'b0);
        tick(10'd94, 10'd400, 2'd1, 1'b1, 1'b0);
        btn_right = 1'b0;
        opp_x = 10'd50;
        btn_left = 1'b1;
        tick(10'd90, 10'd400, 2'd1, 1'b0, 1'b0);
        tick(10'd90, 10'd400, 2'd1, 1'b0, 1'b0);
        btn_left = 1'b0;

        // Right screen clamp at 600
        opp_x = 10'd0;
        btn_right = 1'b1;
        for (int k = 1; k <= 129; k++) begin
            ex = 90 + 4 * k;
            if (ex > 600) ex = 600;
            tick(10'(ex), 10'd400, 2'd1, 1'b1, 1'b0);
        end
        btn_right = 1'b0;
        tick(10'd600, 10'd400, 2'd0, 1'b1, 1'b0);

        // Attack in range, cooldown, auto-repeat
        do_reset();
        opp_x = 10'd70;
        btn_attack = 1'b1;
        tick(10'd20, 10'd400, 2'd3, 1'b1, 1'b1);
        for (int k = 1; k <= 7; k++) tick(10'd20, 10'd400, 2'd3, 1'b1, 1'b0);
        for (int k = 8; k <= 12; k++) tick(10'd20, 10'd400, 2'd0, 1'b1, 1'b0);
        tick(10'd20, 10'd400, 2'd3, 1'b1, 1'b1);
        btn_attack = 1'b0;
        for (int k = 14; k <= 20; k++) tick(10'd20, 10'd400, 2'd3, 1'b1, 1'b0);
        tick(10'd20, 10'd400, 2'd0, 1'b1, 1'b0);

        // Attack out of range: never hits
        do_reset();
        opp_x = 10'd100;
        btn_attack = 1'b1;
        tick(10'd20, 10'd400, 2'd3, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) tick(10'd20, 10'd400, 2'd3, 1'b1, 1'b0);
        tick(10'd20, 10'd400, 2'd0, 1'b1, 1'b0);
        btn_attack = 1'b0;
        tick(10'd20, 10'd400, 2'd0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
